core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 108 ++++++++++
 tb/tb_core_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: fetch/decode/execute/writeback control FSM with fetch timeout and halt-on-fault.
// Optional performance counters (retired_cnt, cycle_cnt) are built when SEQ_PERF_CNT_EN is defined.
module core_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        dec_we,
  output logic        rf_we,
  input  logic        stall,
  output logic [31:0] pc,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt,
`endif
  output logic        halted,
  output logic [1:0]  fault
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  fault_q, fault_d;
  logic        imem_req_q, halted_q;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_q, retired_d, cycle_q, cycle_d;
  always_comb begin
    retired_d = retired_q + 32'(state_q == WRITEBACK);
    cycle_d   = cycle_q + 32'(state_q != HALT);
  end
  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        wait_d  = '0;
      end
      FETCH:
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = DECODE;
        end else if (wait_q == 8'(FETCH_TIMEOUT - 1)) begin
          state_d = HALT;
          fault_d = 2'd2;
        end else
          wait_d = wait_q + 8'd1;
      DECODE: begin
        state_d = (instr_q[6:0] == OP_RTYPE) ? EXECUTE : HALT;
        fault_d = (instr_q[6:0] == OP_RTYPE) ? fault_q : 2'd1;
      end
      EXECUTE: state_d = stall ? EXECUTE : WRITEBACK;
      WRITEBACK: begin
        pc_d    = pc_q + 32'd4;
        state_d = FETCH;
        wait_d  = '0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      wait_q     <= '0;
      fault_q    <= '0;
      imem_req_q <= 1'b0;
      halted_q   <= 1'b0;
`ifdef SEQ_PERF_CNT_EN
      retired_q  <= '0;
      cycle_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wait_q     <= wait_d;
      fault_q    <= fault_d;
      imem_req_q <= state_d == FETCH;
      halted_q   <= state_d == HALT;
`ifdef SEQ_PERF_CNT_EN
      retired_q  <= retired_d;
      cycle_q    <= cycle_d;
`endif
    end
  // the write strobe follows the live decoder enable so it tracks dec_we within the writeback cycle
  assign rf_we     = (state_q == WRITEBACK) && dec_we && (instr_q[11:7] != 5'd0);
  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: randomized and directed checks of core_sequencer against a cycle-count model.
module tb_core_sequencer;
  localparam int T = 16;
  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_ack = 1'b0, dec_we = 1'b0, stall = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, rf_we, halted, imem_req2, rf_we2, halted2;
  logic [31:0] imem_addr, instr, pc, imem_addr2, instr2, pc2;
  logic [1:0]  fault, fault2;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt, cycle_cnt, retired_cnt2, cycle_cnt2;
`endif
  int          checks = 0, passes = 0;
  logic [31:0] exp_pc, exp_instr, exp_ret;

  core_sequencer #(.FETCH_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .dec_we(dec_we), .rf_we(rf_we), .stall(stall), .pc(pc),
`ifdef SEQ_PERF_CNT_EN
    .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt),
`endif
    .halted(halted), .fault(fault));

  core_sequencer #(.RESET_PC(32'hFFFF_FFFC), .FETCH_TIMEOUT(T)) dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr2), .dec_we(dec_we), .rf_we(rf_we2), .stall(stall), .pc(pc2),
`ifdef SEQ_PERF_CNT_EN
    .retired_cnt(retired_cnt2), .cycle_cnt(cycle_cnt2),
`endif
    .halted(halted2), .fault(fault2));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1, "watchdog");
  end

  // leaves the bench 1 time unit into the first FETCH cycle
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; dec_we = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    exp_pc = '0; exp_instr = '0; exp_ret = '0;
  endtask

  // one instruction from the start of FETCH; ack arrives in fetch cycle dly+1, dly>=T means never
  task automatic do_instr(input logic [31:0] w, input int dly, input int stl, input bit we);
    bit legal, tmo, rf_exp;
    int len, fetch_len, ex;
    logic [31:0] pc0, instr0;
    legal = w[6:0] == 7'b0110011;
    tmo = dly >= T;
    pc0 = exp_pc; instr0 = exp_instr;
    fetch_len = tmo ? T : dly + 1;
    len = tmo ? T : (legal ? dly + 4 + stl : dly + 2);
    ex = dly + 3;
    for (int c = 1; c <= len; c++) begin
      imem_ack = !tmo && c == dly + 1;
      imem_rdata = imem_ack ? w : $urandom;
      dec_we = we;
      stall = (legal && !tmo && c >= ex && c < len) ? (c < ex + stl) : 1'($urandom_range(0, 1));
      #1;
      rf_exp = legal && !tmo && c == len && we && w[11:7] != 5'd0;
      checks++;
      if ({imem_req, rf_we, halted, pc} !== {c <= fetch_len, rf_exp, 1'b0, pc0})
        $display("FAIL cycle %0d: req/rf_we/halted/pc got %b %b %b %h want %b %b 0 %h",
                 c, imem_req, rf_we, halted, pc, c <= fetch_len, rf_exp, pc0);
      else passes++;
      if (c <= fetch_len) begin
        checks++;
        if (imem_addr !== pc0) $display("FAIL imem_addr: got %h want %h", imem_addr, pc0);
        else passes++;
      end
      @(posedge clk); #1;
    end
    imem_ack = 1'b0; stall = 1'b0;
    if (tmo || !legal) begin
      for (int k = 0; k < 4; k++) begin
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom; stall = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if ({halted, fault, imem_req, rf_we, pc, instr} !== {1'b1, tmo ? 2'd2 : 2'd1, 2'b00, pc0, tmo ? instr0 : w})
          $display("FAIL halt: halted/fault/req/rf_we/pc/instr got %b %0d %b %b %h %h want 1 %0d 0 0 %h %h",
                   halted, fault, imem_req, rf_we, pc, instr, tmo ? 2 : 1, pc0, tmo ? instr0 : w);
        else passes++;
        @(posedge clk); #1;
      end
      imem_ack = 1'b0;
    end else begin
      exp_pc = pc0 + 32'd4; exp_instr = w; exp_ret++;
      checks++;
      if ({pc, instr, imem_req, halted, fault, pc2} !== {exp_pc, w, 2'b10, 2'd0, exp_pc + 32'hFFFF_FFFC})
        $display("FAIL retire: pc/instr/req/halted/fault/pc2 got %h %h %b %b %0d %h want %h %h 1 0 0 %h",
                 pc, instr, imem_req, halted, fault, pc2, exp_pc, w, exp_pc + 32'hFFFF_FFFC);
      else passes++;
`ifdef SEQ_PERF_CNT_EN
      checks++;
      if (retired_cnt !== exp_ret) $display("FAIL retired_cnt: got %0d want %0d", retired_cnt, exp_ret);
      else passes++;
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h002081B3; stall = 1'b1; dec_we = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_req, rf_we, halted, fault, pc, instr, pc2} !== {3'b000, 2'd0, 32'd0, 32'd0, 32'hFFFF_FFFC})
      $display("FAIL reset: req/rf_we/halted/fault/pc/instr/pc2 got %b %b %b %0d %h %h %h",
               imem_req, rf_we, halted, fault, pc, instr, pc2);
    else passes++;
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", imem_req);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || instr !== 32'd0) $display("FAIL first_fetch: req %b instr %h want 1 0", imem_req, instr);
    else passes++;
    exp_pc = '0; exp_instr = '0; exp_ret = '0; stall = 1'b0;
  endtask

  task automatic test_add();
    do_instr(32'h002081B3, 0, 0, 1'b1);
  endtask

  task automatic test_rd_zero();
    do_instr(32'h00000033, 0, 0, 1'b1);
  endtask

  task automatic test_stall();
    do_instr(32'h002081B3, 0, 3, 1'b1);
  endtask

  task automatic test_illegal();
    do_reset();
    do_instr(32'h00000013, 0, 0, 1'b1);
  endtask

  task automatic test_timeout();
    do_reset();
    do_instr(32'h002081B3, T, 0, 1'b1);
    do_reset();
    do_instr(32'h002081B3, T - 1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    do_instr(32'h002081B3, 0, 0, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 32'd0) $display("FAIL async_reset: req %b pc %h want 0 0", imem_req, pc);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h00A08033;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr !== 32'd0) $display("FAIL late_ack: req %b instr %h want 0 0", imem_req, instr);
    else passes++;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    exp_pc = '0; exp_instr = '0; exp_ret = '0;
    do_instr(32'h00A08033, 2, 1, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] w;
    int dly;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      w[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'b0110011;
      if ($urandom_range(0, 5) == 0) w[11:7] = 5'd0;
      case ($urandom_range(0, 9))
        0: dly = T - 1;
        1: dly = T;
        default: dly = $urandom_range(0, 5);
      endcase
      do_instr(w, dly, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if (dly >= T || w[6:0] != 7'b0110011) do_reset();
    end
  endtask

  initial begin
    exp_pc = '0; exp_instr = '0; exp_ret = '0;
    test_reset();
    test_add();
    test_rd_zero();
    test_stall();
    test_illegal();
    test_timeout();
    test_reset_mid_fetch();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
